// File: rtl/btn_debounce_pkg.sv
// Shared definitions for the push-button front end and the button read port.
package btn_debounce_pkg;

  // Number of push buttons on the board (S0..S4).
  localparam int N_BTN_DEF = 5;

  // Memory-mapped address decoded by the button read port.
  localparam logic [31:0] BTN_ADDR = 32'hFFFF_F078;

  // Default debounce window: 20 ms at a 25 MHz board clock.
  localparam int DB_CYCLES_DEF = 500000;

  // Counter width able to hold 0..cycles-1; never narrower than one bit.
  function automatic int cnt_width(input int cycles);
    int w;
    w = $clog2(cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/btn_db_cell.sv
// One button channel: 2-FF synchroniser, debounce counter, stable level and
// registered press/release pulses.
module btn_db_cell
  import btn_debounce_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic stable_o,
  output logic press_o,
  output logic release_o,
  output logic press_next_o
);

  localparam int              CNT_W   = cnt_width(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic             s1_q;
  logic             s2_q;
  logic             stable_q;
  logic             stable_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             press_q;
  logic             release_q;
  logic             flip_s;

  // Next-state for the debounce counter and the stable level.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    flip_s   = 1'b0;
    if (s2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      flip_s   = 1'b1;
      stable_d = s2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Synchroniser, counter, stable level and edge pulses; reset clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      cnt_q     <= '0;
      stable_q  <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      s1_q      <= raw_i;
      s2_q      <= s1_q;
      cnt_q     <= cnt_d;
      stable_q  <= stable_d;
      press_q   <= flip_s & s2_q;
      release_q <= flip_s & ~s2_q;
    end
  end

  assign stable_o     = stable_q;
  assign press_o      = press_q;
  assign release_o    = release_q;
  // Press that will appear on press_o at the next edge; lets the latch set in step.
  assign press_next_o = flip_s & s2_q;

endmodule

// File: rtl/btn_debounce.sv
// Push-button front end: per-pin debounce cells plus a sticky press latch that
// a CPU read of the button address clears.
module btn_debounce
  import btn_debounce_pkg::*;
#(
  parameter int N_BTN     = N_BTN_DEF,
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] button_raw,
  input  logic             rd_clr,
  output logic [N_BTN-1:0] btn_stable,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_latched
);

  logic [N_BTN-1:0] press_next_s;
  logic [N_BTN-1:0] latched_q;
  logic [N_BTN-1:0] latched_d;

  for (genvar i = 0; i < N_BTN; i++) begin : g_cell
    btn_db_cell #(
      .DB_CYCLES(DB_CYCLES)
    ) u_cell (
      .clk         (clk),
      .rst         (rst),
      .raw_i       (button_raw[i]),
      .stable_o    (btn_stable[i]),
      .press_o     (btn_press[i]),
      .release_o   (btn_release[i]),
      .press_next_o(press_next_s[i])
    );
  end

  // Latch next-state: a press landing with rd_clr still sets, so no press is lost.
  always_comb begin
    latched_d = (latched_q & ~{N_BTN{rd_clr}}) | press_next_s;
  end

  // Sticky press latch register.
  always_ff @(posedge clk) begin
    if (rst) begin
      latched_q <= '0;
    end else begin
      latched_q <= latched_d;
    end
  end

  assign btn_latched = latched_q;

endmodule
